// File: rtl/angle_pkg.sv
// angle_pkg: shared constants for the angle tracker and its prescaler.
//   freq_e  - free-run mode encoding driven on the freq input
//   *_DEF   - default widths, prescaler terminal counts and timeout
package angle_pkg;

    typedef enum logic [1:0] {
        FREQ_60   = 2'd0,
        FREQ_50   = 2'd1,
        FREQ_CLK  = 2'd2,
        FREQ_HOLD = 2'd3
    } freq_e;

    localparam int unsigned THETA_W_DEF   = 10;
    localparam int unsigned DIV_W_DEF     = 9;
    localparam int unsigned DIV_60HZ_DEF  = 408;
    localparam int unsigned DIV_50HZ_DEF  = 489;
    localparam int unsigned TMO_STEPS_DEF = 1024;

endpackage

// File: rtl/angle_prescaler.sv
// angle_prescaler: divides clk down to one step strobe every DIV+1 clocks.
//   clk, RESET_N - clock, asynchronous active-low reset
//   freq         - mode select (see angle_pkg::freq_e)
//   clear        - restart the count (a load was accepted)
//   step_c       - combinational step strobe, high in the cycle the count sits at DIV
module angle_prescaler
    import angle_pkg::*;
#(
    parameter int unsigned DIV_W    = DIV_W_DEF,
    parameter int unsigned DIV_60HZ = DIV_60HZ_DEF,
    parameter int unsigned DIV_50HZ = DIV_50HZ_DEF
) (
    input  logic       clk,
    input  logic       RESET_N,
    input  logic [1:0] freq,
    input  logic       clear,
    output logic       step_c
);

    freq_e            mode;
    logic [DIV_W-1:0] div_c;
    logic [DIV_W-1:0] cnt;
    logic [1:0]       prev_freq;
    logic             prev_valid;
    logic             freq_chg_c;

    assign mode = freq_e'(freq);

    // Terminal count for the selected mode; hold mode never reaches a step.
    always_comb begin
        div_c = '0;
        case (mode)
            FREQ_60: div_c = DIV_W'(DIV_60HZ);
            FREQ_50: div_c = DIV_W'(DIV_50HZ);
            default: div_c = '0;
        endcase
    end

    // prev_valid keeps the first cycle after reset from looking like a mode change.
    assign freq_chg_c = prev_valid && (freq != prev_freq);
    assign step_c     = (mode != FREQ_HOLD) && !freq_chg_c && (cnt == div_c);

    // Divider count and mode history.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt        <= '0;
            prev_freq  <= 2'd0;
            prev_valid <= 1'b0;
        end else begin
            if (clear || freq_chg_c || (mode == FREQ_HOLD) || step_c) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
            prev_freq  <= freq;
            prev_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/angle_tracker.sv
// angle_tracker: tracks an external electrical angle and free-runs between loads.
//   clk, RESET_N  - clock, asynchronous active-low reset
//   theta_in      - measured angle, qualified by theta_valid
//   freq          - 0 = 60 Hz, 1 = 50 Hz, 2 = step every clock, 3 = hold
//   sequence_in   - 1 = increment per step, 0 = decrement
//   theta_out     - tracked angle
//   CYCLE         - one-cycle pulse on wrap in either direction
//   STEP          - one-cycle pulse on each self-generated step
//   STALE         - sticky, set after TMO_STEPS steps without a load
module angle_tracker
    import angle_pkg::*;
#(
    parameter int unsigned THETA_W   = THETA_W_DEF,
    parameter int unsigned DIV_W     = DIV_W_DEF,
    parameter int unsigned DIV_60HZ  = DIV_60HZ_DEF,
    parameter int unsigned DIV_50HZ  = DIV_50HZ_DEF,
    parameter int unsigned TMO_STEPS = TMO_STEPS_DEF
) (
    input  logic               clk,
    input  logic               RESET_N,
    input  logic [THETA_W-1:0] theta_in,
    input  logic               theta_valid,
    input  logic [1:0]         freq,
    input  logic               sequence_in,
    output logic [THETA_W-1:0] theta_out,
    output logic               CYCLE,
    output logic               STEP,
    output logic               STALE
);

    localparam int unsigned TMO_W = $clog2(TMO_STEPS + 1);

    logic [THETA_W-1:0] last_theta;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [TMO_W-1:0]   tmo_next_c;
    logic [THETA_W-1:0] theta_step_c;
    logic               load_c;
    logic               step_c;
    logic               step_take_c;
    logic               wrap_c;

    // A repeated sample is not a load, so it neither restarts the prescaler nor clears STALE.
    assign load_c      = theta_valid && (theta_in != last_theta);
    assign step_take_c = step_c && !load_c;

    angle_prescaler #(
        .DIV_W    (DIV_W),
        .DIV_60HZ (DIV_60HZ),
        .DIV_50HZ (DIV_50HZ)
    ) u_prescaler (
        .clk     (clk),
        .RESET_N (RESET_N),
        .freq    (freq),
        .clear   (load_c),
        .step_c  (step_c)
    );

    // Next angle and wrap flag for a step in the current direction.
    always_comb begin
        theta_step_c = theta_out;
        wrap_c       = 1'b0;
        if (sequence_in) begin
            theta_step_c = theta_out + THETA_W'(1);
            wrap_c       = (theta_out == {THETA_W{1'b1}});
        end else begin
            theta_step_c = theta_out - THETA_W'(1);
            wrap_c       = (theta_out == '0);
        end
    end

    assign tmo_next_c = (tmo_cnt == TMO_W'(TMO_STEPS)) ? tmo_cnt : tmo_cnt + TMO_W'(1);

    // Angle register, event pulses and timeout tracking.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            theta_out  <= '0;
            last_theta <= '0;
            tmo_cnt    <= '0;
            CYCLE      <= 1'b0;
            STEP       <= 1'b0;
            STALE      <= 1'b0;
        end else begin
            CYCLE <= 1'b0;
            STEP  <= 1'b0;
            if (load_c) begin
                theta_out  <= theta_in;
                last_theta <= theta_in;
                tmo_cnt    <= '0;
                STALE      <= 1'b0;
            end else if (step_take_c) begin
                theta_out <= theta_step_c;
                CYCLE     <= wrap_c;
                STEP      <= 1'b1;
                tmo_cnt   <= tmo_next_c;
                if (tmo_next_c == TMO_W'(TMO_STEPS)) begin
                    STALE <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_angle_tracker.sv
// tb_angle_tracker: directed scenarios plus randomized traffic, every cycle
// compared against a timestamp-based reference model of the tracker.
module tb_angle_tracker;

    localparam int TW   = 10;
    localparam int FULL = 1024;
    localparam int TMO  = 4;

    logic          clk;
    logic          RESET_N;
    logic [TW-1:0] theta_in;
    logic          theta_valid;
    logic [1:0]    freq;
    logic          sequence_in;
    logic [TW-1:0] theta_out;
    logic          CYCLE;
    logic          STEP;
    logic          STALE;

    int n_checks;
    int n_errors;

    // reference model state
    int m_theta, m_last, m_edge, m_anchor, m_steps, m_pf;
    bit m_pv, m_cycle, m_step, m_stale;

    angle_tracker #(
        .THETA_W   (TW),
        .DIV_W     (9),
        .DIV_60HZ  (408),
        .DIV_50HZ  (489),
        .TMO_STEPS (TMO)
    ) dut (
        .clk         (clk),
        .RESET_N     (RESET_N),
        .theta_in    (theta_in),
        .theta_valid (theta_valid),
        .freq        (freq),
        .sequence_in (sequence_in),
        .theta_out   (theta_out),
        .CYCLE       (CYCLE),
        .STEP        (STEP),
        .STALE       (STALE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int div_of(input logic [1:0] f);
        case (f)
            2'd0:    return 408;
            2'd1:    return 489;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_theta = 0; m_last = 0; m_edge = 0; m_anchor = 0; m_steps = 0;
        m_pf = 0; m_pv = 0; m_cycle = 0; m_step = 0; m_stale = 0;
    endtask

    // One rising edge: a step is due DIV+1 edges after the last restart.
    task automatic model_edge();
        bit load, chg, hold, fire;
        m_edge++;
        load = theta_valid && (int'(theta_in) != m_last);
        chg  = m_pv && (int'(freq) != m_pf);
        hold = (freq == 2'd3);
        fire = !hold && !chg && (m_edge - m_anchor == div_of(freq) + 1);
        m_cycle = 0;
        m_step  = 0;
        if (load) begin
            m_theta  = int'(theta_in);
            m_last   = int'(theta_in);
            m_anchor = m_edge;
            m_steps  = 0;
            m_stale  = 0;
        end else if (fire) begin
            m_step = 1;
            if (sequence_in) begin
                m_cycle = (m_theta == FULL - 1);
                m_theta = (m_theta + 1) % FULL;
            end else begin
                m_cycle = (m_theta == 0);
                m_theta = (m_theta + FULL - 1) % FULL;
            end
            m_anchor = m_edge;
            if (m_steps < TMO) m_steps++;
            if (m_steps == TMO) m_stale = 1;
        end else if (hold || chg) begin
            m_anchor = m_edge;
        end
        m_pf = int'(freq);
        m_pv = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("theta_model", theta_out, m_theta);
        check_eq("flags_model", {CYCLE, STEP, STALE}, {m_cycle, m_step, m_stale});
    endtask

    task automatic load(input int v);
        theta_valid = 1'b1;
        theta_in    = TW'(v);
        tick();
        theta_valid = 1'b0;
    endtask

    // Clocks until the next STEP pulse, bounded.
    task automatic wait_step(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!STEP && n < limit);
    endtask

    initial begin
        int n, cyc_at, stp, th0;
        n_checks = 0;
        n_errors = 0;
        theta_in = '0; theta_valid = 1'b0; freq = 2'd2; sequence_in = 1'b1;

        // reset
        RESET_N = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_theta", theta_out, 0);
        check_eq("rst_flags", {CYCLE, STEP, STALE}, 0);
        @(negedge clk) RESET_N = 1'b1;

        // mode 2 sawtooth from 0: wrap at clock 1024
        cyc_at = 0;
        for (int i = 1; i <= 1030; i++) begin
            tick();
            if (i == 3) check_eq("stale_pre", STALE, 0);
            if (i == 4) check_eq("stale_4th", {STEP, STALE}, 2'b11);
            if (i == 1023) check_eq("saw_top", theta_out, 1023);
            if (CYCLE && cyc_at == 0) cyc_at = i;
        end
        check_eq("wrap_clock", cyc_at, 1024);

        // mode 0 load 100: step period 409
        freq = 2'd0;
        load(100);
        check_eq("load_100", theta_out, 100);
        wait_step(1000, n);
        check_eq("first_gap60", n, 409);
        check_eq("step_101", theta_out, 101);
        wait_step(1000, n);
        check_eq("second_gap60", n, 409);

        // mode 2 decrement through zero
        freq = 2'd2; sequence_in = 1'b0;
        load(1);
        check_eq("load_1", theta_out, 1);
        tick(); check_eq("dec_0", {theta_out, CYCLE}, {10'd0, 1'b0});
        tick(); check_eq("dec_wrap", {theta_out, CYCLE}, {10'd1023, 1'b1});
        tick(); check_eq("dec_1022", {theta_out, CYCLE}, {10'd1022, 1'b0});

        // load colliding with the prescaler terminal count
        freq = 2'd0; sequence_in = 1'b1;
        load(499);
        repeat (408) tick();
        load(500);
        check_eq("collide_load", {theta_out, STEP}, {10'd500, 1'b0});
        repeat (200) tick();
        load(500);
        wait_step(1000, n);
        check_eq("no_reload_gap", n, 208);
        check_eq("no_reload_val", theta_out, 501);

        // timeout with TMO_STEPS = 4
        freq = 2'd2;
        load(3);
        check_eq("stale_clr_ld", STALE, 0);
        repeat (3) tick();
        check_eq("stale_3rd", STALE, 0);
        tick();
        check_eq("stale_set", {STEP, STALE}, 2'b11);
        repeat (3) tick();
        check_eq("stale_sticky", STALE, 1);
        load(7);
        check_eq("stale_load7", {theta_out, STALE}, {10'd7, 1'b0});

        // hold mode
        freq = 2'd3;
        tick();
        th0 = int'(theta_out);
        stp = 0;
        repeat (2000) begin
            tick();
            if (STEP) stp++;
        end
        check_eq("hold_steps", stp, 0);
        check_eq("hold_theta", theta_out, th0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            freq        = ($urandom_range(0, 9) < 6) ? 2'd2 : 2'($urandom_range(0, 3));
            theta_valid = ($urandom_range(0, 7) == 0);
            theta_in    = ($urandom_range(0, 3) == 0) ? TW'(m_last) : TW'($urandom);
            if ($urandom_range(0, 31) == 0) sequence_in = ~sequence_in;
            tick();
        end
        theta_valid = 1'b0;

        // asynchronous reset mid-count in mode 0
        freq = 2'd0; sequence_in = 1'b1;
        load(321);
        repeat (100) tick();
        #2 RESET_N = 1'b0;
        #1;
        check_eq("async_theta", theta_out, 0);
        check_eq("async_flags", {CYCLE, STEP, STALE}, 0);
        model_reset();
        @(negedge clk) RESET_N = 1'b1;
        wait_step(1000, n);
        check_eq("post_rst_gap", n, 409);
        check_eq("post_rst_val", theta_out, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
